// File: rtl/game_cfg_sequencer_if.sv
// Game identifiers and the request/status bundle between the board controller
// and the configuration sequencer.
package game_cfg_pkg;
    typedef logic [3:0] game_t;

    localparam game_t GAME_NONE    = 4'd0;
    localparam game_t GAME_FINALB  = 4'd1;
    localparam game_t GAME_QJINSEI = 4'd2;
    localparam game_t GAME_DINOREX = 4'd3;
endpackage

interface game_cfg_sequencer_if;
    import game_cfg_pkg::*;

    logic        cfg_req;
    game_t       game;
    logic        core_idle;
    logic        busy;
    logic        cfg_ack;
    logic        drain_timeout;
    logic        core_rst_n;
    logic        cfg_360pri;
    logic        cfg_110pcr;
    logic        cfg_260dar;
    logic [1:0]  cfg_obj_extender;

    modport master (
        output cfg_req, game, core_idle,
        input  busy, cfg_ack, drain_timeout, core_rst_n,
        input  cfg_360pri, cfg_110pcr, cfg_260dar, cfg_obj_extender
    );

    modport slave (
        input  cfg_req, game, core_idle,
        output busy, cfg_ack, drain_timeout, core_rst_n,
        output cfg_360pri, cfg_110pcr, cfg_260dar, cfg_obj_extender
    );
endinterface

// File: rtl/game_cfg_sequencer.sv
// Sequences a board-core reconfiguration: drain bus activity, hold the core in
// reset, load the chip-option selects for the requested game, settle, release.
module game_cfg_sequencer
    import game_cfg_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned DRAIN_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    game_cfg_sequencer_if.slave  bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DRAIN   = 3'd1;
    localparam logic [2:0] S_HOLD    = 3'd2;
    localparam logic [2:0] S_LOAD    = 3'd3;
    localparam logic [2:0] S_SETTLE  = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    // Counters count down to zero, so each load value is one less than the duration.
    localparam logic [7:0] DRAIN_LOAD  = 8'(DRAIN_TIMEOUT - 1);
    localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    // cfg vector layout: {360pri, 260dar, 110pcr, obj_extender[1:0]}
    function automatic logic [4:0] decode_cfg(input game_t g);
        logic [4:0] c;
        case (g)
            GAME_FINALB:  c = 5'b00100;
            GAME_QJINSEI: c = 5'b11001;
            GAME_DINOREX: c = 5'b11001;
            default:      c = 5'b00000;
        endcase
        return c;
    endfunction

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    game_t      cur_game_q, cur_game_d;
    logic       pend_vld_q, pend_vld_d;
    game_t      pend_game_q, pend_game_d;
    logic       busy_q, busy_d;
    logic       ack_q, ack_d;
    logic       dto_q, dto_d;
    logic       crst_n_q, crst_n_d;
    logic [4:0] cfg_q, cfg_d;

    // Sequencer state, cycle counter, latched game and option selects.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_game_d = cur_game_q;
        dto_d      = dto_q;
        cfg_d      = cfg_q;
        case (state_q)
            S_IDLE: begin
                if (pend_vld_q) begin
                    state_d    = S_DRAIN;
                    cnt_d      = DRAIN_LOAD;
                    cur_game_d = pend_game_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (bus.core_idle) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LOAD;
                end else if (cnt_q == 8'd0) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LOAD;
                    dto_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_LOAD;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_LOAD: begin
                cfg_d   = decode_cfg(cur_game_q);
                state_d = S_SETTLE;
                cnt_d   = SETTLE_LOAD;
            end
            S_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_RELEASE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // One-deep pending request; a new strobe wins over consumption in the same cycle.
    always_comb begin
        pend_vld_d  = pend_vld_q;
        pend_game_d = pend_game_q;
        if (bus.cfg_req) begin
            pend_vld_d  = 1'b1;
            pend_game_d = bus.game;
        end else if ((state_q == S_IDLE) && pend_vld_q) begin
            pend_vld_d = 1'b0;
        end else begin
            pend_vld_d = pend_vld_q;
        end
    end

    // Status outputs are decoded from the next state so they align with it once registered.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        ack_d  = (state_d == S_RELEASE);
        if (state_d == S_HOLD) begin
            crst_n_d = 1'b0;
        end else if (state_d == S_RELEASE) begin
            crst_n_d = 1'b1;
        end else begin
            crst_n_d = crst_n_q;
        end
    end

    // All sequencer state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            cur_game_q  <= GAME_NONE;
            pend_vld_q  <= 1'b0;
            pend_game_q <= GAME_NONE;
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
            dto_q       <= 1'b0;
            crst_n_q    <= 1'b0;
            cfg_q       <= 5'b00000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_game_q  <= cur_game_d;
            pend_vld_q  <= pend_vld_d;
            pend_game_q <= pend_game_d;
            busy_q      <= busy_d;
            ack_q       <= ack_d;
            dto_q       <= dto_d;
            crst_n_q    <= crst_n_d;
            cfg_q       <= cfg_d;
        end
    end

    assign bus.busy             = busy_q;
    assign bus.cfg_ack          = ack_q;
    assign bus.drain_timeout    = dto_q;
    assign bus.core_rst_n       = crst_n_q;
    assign bus.cfg_360pri       = cfg_q[4];
    assign bus.cfg_260dar       = cfg_q[3];
    assign bus.cfg_110pcr       = cfg_q[2];
    assign bus.cfg_obj_extender = cfg_q[1:0];

endmodule

// File: tb/tb_game_cfg_sequencer.sv
// Scoreboard bench for game_cfg_sequencer: expected ack results are queued per
// request and checked against the DUT when cfg_ack pulses.
module tb_game_cfg_sequencer;
    import game_cfg_pkg::*;

    typedef struct {
        logic [4:0] cfg;
        int         busy_cyc;
        int         low_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    game_cfg_sequencer_if bus();

    game_cfg_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         ack_cnt = 0;
    int         busy_cnt = 0;
    int         low_cnt = 0;
    logic [4:0] hist[0:9];
    logic [4:0] prev_cfg = 5'b00000;
    logic       prev_ack = 1'b0;
    bit         first_seq = 1'b1;
    logic [4:0] obs_cfg;

    assign obs_cfg = {bus.cfg_360pri, bus.cfg_260dar, bus.cfg_110pcr, bus.cfg_obj_extender};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {360pri, 260dar, 110pcr, obj_extender}
    function automatic logic [4:0] model_cfg(input game_t g);
        if (g == GAME_FINALB) return 5'b0_0_1_00;
        else if (g == GAME_QJINSEI || g == GAME_DINOREX) return 5'b1_1_0_01;
        else return 5'b0_0_0_00;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // drain: expected DRAIN cycles; replace: overwrite the still-pending queued entry.
    task automatic send_req(input game_t g, input int drain, input bit replace, input bit expect_ack);
        exp_t e;
        e.cfg      = model_cfg(g);
        e.busy_cyc = drain + 26;
        e.low_cyc  = first_seq ? drain + 25 : 25;
        if (expect_ack) begin
            if (replace) exp_q[exp_q.size() - 1].cfg = e.cfg;
            else exp_q.push_back(e);
            first_seq = 1'b0;
        end
        bus.cfg_req = 1'b1;
        bus.game    = g;
        tick(1);
        bus.cfg_req = 1'b0;
        bus.game    = GAME_NONE;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick(1);
        check_eq("acks_within_budget", exp_q.size(), 0);
        tick(3);
    endtask

    // Monitor: per-sequence cycle counts and cfg history, scoreboard pop on ack.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            busy_cnt = 0;
            low_cnt  = 0;
            prev_cfg = 5'b00000;
            prev_ack = 1'b0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.busy && !bus.core_rst_n) low_cnt++;
            if (prev_ack && bus.cfg_ack) check_eq("ack_single_cycle", 1, 0);
            if (bus.cfg_ack) begin
                ack_cnt++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_ack", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("ack_cfg", obs_cfg, e.cfg);
                    check_eq("cfg_first_settle", hist[7], e.cfg);
                    check_eq("cfg_during_load", hist[8], prev_cfg);
                    check_eq("busy_cycles", busy_cnt, e.busy_cyc);
                    check_eq("rst_low_cycles", low_cnt, e.low_cyc);
                    check_eq("rst_high_at_ack", bus.core_rst_n, 1);
                    prev_cfg = e.cfg;
                end
                busy_cnt = 0;
                low_cnt  = 0;
            end
            prev_ack = bus.cfg_ack;
        end
        for (int k = 9; k > 0; k--) hist[k] = hist[k - 1];
        hist[0] = obs_cfg;
    end

    initial begin
        int acks0;
        reset_n       = 1'b0;
        bus.cfg_req   = 1'b0;
        bus.game      = GAME_NONE;
        bus.core_idle = 1'b1;
        tick(3);
        check_eq("rst_core_rst_n", bus.core_rst_n, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_ack", bus.cfg_ack, 0);
        check_eq("rst_dto", bus.drain_timeout, 0);
        check_eq("rst_cfg", obs_cfg, 5'b00000);
        reset_n = 1'b1;
        tick(5);
        check_eq("core_rst_held_after_reset", bus.core_rst_n, 0);
        check_eq("idle_not_busy", bus.busy, 0);

        // Basic QJINSEI sequence straight out of reset
        send_req(GAME_QJINSEI, 1, 1'b0, 1'b1);
        wait_done(100);
        check_eq("first_ack_count", ack_cnt, 1);
        check_eq("core_rst_released", bus.core_rst_n, 1);

        // Drain timeout with core never idle
        bus.core_idle = 1'b0;
        check_eq("dto_before", bus.drain_timeout, 0);
        send_req(GAME_FINALB, 255, 1'b0, 1'b1);
        wait_done(400);
        bus.core_idle = 1'b1;
        check_eq("dto_set", bus.drain_timeout, 1);

        // FINALB, then DINOREX requested during HOLD
        acks0 = ack_cnt;
        send_req(GAME_FINALB, 1, 1'b0, 1'b1);
        tick(6);
        check_eq("in_hold_rst_low", bus.core_rst_n, 0);
        send_req(GAME_DINOREX, 1, 1'b0, 1'b1);
        wait_done(200);
        check_eq("hold_req_acks", ack_cnt - acks0, 2);
        check_eq("hold_req_final_cfg", obs_cfg, 5'b11001);
        check_eq("dto_sticky", bus.drain_timeout, 1);

        // DINOREX, then FINALB overwritten by QJINSEI while busy
        acks0 = ack_cnt;
        send_req(GAME_DINOREX, 1, 1'b0, 1'b1);
        tick(4);
        send_req(GAME_FINALB, 1, 1'b0, 1'b1);
        tick(3);
        send_req(GAME_QJINSEI, 1, 1'b1, 1'b1);
        wait_done(200);
        check_eq("last_wins_acks", ack_cnt - acks0, 2);

        // Request coinciding with the IDLE->DRAIN transition
        acks0 = ack_cnt;
        send_req(GAME_FINALB, 1, 1'b0, 1'b1);
        send_req(GAME_QJINSEI, 1, 1'b0, 1'b1);
        wait_done(200);
        check_eq("coincident_acks", ack_cnt - acks0, 2);

        // Unknown game value
        send_req(4'hF, 1, 1'b0, 1'b1);
        wait_done(100);
        check_eq("unknown_cfg_zero", obs_cfg, 5'b00000);

        // Reset during SETTLE, with a further request pending
        bus.core_idle = 1'b1;
        send_req(GAME_DINOREX, 1, 1'b0, 1'b0);
        tick(20);
        send_req(GAME_FINALB, 1, 1'b0, 1'b0);
        check_eq("settle_busy", bus.busy, 1);
        check_eq("settle_rst_low", bus.core_rst_n, 0);
        check_eq("settle_cfg_loaded", obs_cfg, 5'b11001);
        acks0 = ack_cnt;
        reset_n = 1'b0;
        #1;
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_cfg", obs_cfg, 5'b00000);
        check_eq("abort_dto", bus.drain_timeout, 0);
        check_eq("abort_core_rst", bus.core_rst_n, 0);
        check_eq("abort_ack", bus.cfg_ack, 0);
        tick(2);
        reset_n   = 1'b1;
        first_seq = 1'b1;
        tick(40);
        check_eq("abort_stays_idle", bus.busy, 0);
        check_eq("abort_no_ack", ack_cnt - acks0, 0);
        check_eq("abort_rst_still_low", bus.core_rst_n, 0);

        send_req(GAME_QJINSEI, 1, 1'b0, 1'b1);
        wait_done(100);
        check_eq("post_abort_cfg", obs_cfg, 5'b11001);
        check_eq("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/game_cfg_sequencer.md
GAME_CFG_SEQUENCER -- requirements
Module: game_cfg_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 16: cycles core_rst_n is held low before the new config is loaded; legal range 1..255.
REQ-002 Parameter SETTLE_CYCLES, default 8: cycles after the config is loaded before reset is released; legal range 1..255.
REQ-003 Parameter DRAIN_TIMEOUT, default 255: maximum cycles spent waiting for core_idle; legal range 1..255.
REQ-004 Port: clk, input, 1, single system clock; all logic is clocked on posedge.
REQ-005 Port: reset_n, input, 1, asynchronous active-low reset.
REQ-006 Port: cfg_req, input, 1, single-cycle strobe requesting a switch to the game on `game`.
REQ-007 Port: game, input, game_t, requested game; sampled only when cfg_req=1.
REQ-008 Port: core_idle, input, 1, high when the board core has no bus cycle in flight.
REQ-009 Port: busy, output, 1, high in every state except IDLE.
REQ-010 Port: cfg_ack, output, 1, one-cycle pulse when a reconfiguration completes.
REQ-011 Port: drain_timeout, output, 1, sticky flag; set when a drain expires without core_idle.
REQ-012 Port: core_rst_n, output, 1, active-low reset to the board core.
REQ-013 Port: cfg_360pri, cfg_110pcr, cfg_260dar, output, 1 each, registered chip-option selects.
REQ-014 Port: cfg_obj_extender, output, 2, registered object-extender mode.

Function
REQ-015 FSM states are IDLE, DRAIN, HOLD, LOAD, SETTLE and RELEASE.
REQ-016 IDLE -> DRAIN when a request is pending; the pending game is latched into cur_game on that transition.
REQ-017 DRAIN -> HOLD on core_idle=1, or after DRAIN_TIMEOUT cycles in DRAIN, whichever comes first.
REQ-018 On a drain timeout, drain_timeout is set to 1 and stays set until reset.
REQ-019 core_rst_n goes low on the first HOLD cycle and stays low through HOLD, LOAD and SETTLE.
REQ-020 HOLD lasts exactly HOLD_CYCLES cycles, then -> LOAD.
REQ-021 LOAD lasts one cycle and updates the cfg outputs from cur_game as follows:
- GAME_FINALB: 360pri=0, 260dar=0, 110pcr=1, obj_extender=00.
- GAME_QJINSEI: 360pri=1, 260dar=1, 110pcr=0, obj_extender=01.
- GAME_DINOREX: 360pri=1, 260dar=1, 110pcr=0, obj_extender=01.
- Any other game: all zero.
REQ-022 Cfg outputs change only in LOAD and are stable in all other states.
REQ-023 SETTLE lasts exactly SETTLE_CYCLES cycles, then -> RELEASE.
REQ-024 In RELEASE, core_rst_n=1 and cfg_ack=1 for one cycle, then -> IDLE.
REQ-025 Pending request buffering:
- cfg_req in any state stores `game` in a one-deep pending register.
- A later cfg_req overwrites the stored game (last request wins).
- The pending flag clears when IDLE consumes the request.
REQ-026 A cfg_req in the same cycle as the IDLE->DRAIN transition is not lost: it becomes the next pending request.
REQ-027 A request for the game already loaded still executes the full sequence.
REQ-028 All cycle counters are 8 bits, load at state entry, and never wrap.

Reset
REQ-029 While reset_n=0, outputs are asynchronously forced to the following values:
- core_rst_n=0
- busy=0
- cfg_ack=0
- drain_timeout=0
- all cfg outputs = 0
REQ-030 While reset_n=0, the FSM is forced to IDLE and the pending flag to 0.
REQ-031 After reset deassertion, core_rst_n remains 0 until the first reconfiguration reaches RELEASE.
REQ-032 Reset asserted mid-sequence aborts the sequence with no cfg_ack and discards any pending request.

Verification
REQ-033 Reset, then cfg_req with game=GAME_QJINSEI and core_idle=1 -> cfg 1/1/0/01 appear one cycle after HOLD ends; cfg_ack pulses once; core_rst_n is low for 16+1+8 cycles.
REQ-034 core_idle held at 0 -> DRAIN exits after 255 cycles; drain_timeout=1; the sequence completes normally.
REQ-035 Requests GAME_FINALB then GAME_DINOREX during HOLD -> after the first ack, a second sequence runs; final cfg = 1/1/0/01; exactly 2 acks.
REQ-036 Requests GAME_DINOREX then GAME_FINALB, then GAME_QJINSEI, all while busy -> the second sequence loads QJINSEI only; exactly 2 acks.
REQ-037 reset_n pulsed low during SETTLE -> all outputs return to reset values immediately; no ack; the FSM stays idle until a new cfg_req.
REQ-038 Unknown game value -> all cfg outputs are 0 after LOAD; cfg_ack still pulses.
